i2s_transceiver: RTL and testbench

Single-clock I2S serial audio block with a master transmitter and a slave receiver sharing one bit clock. The transmit path generates the word-select clock and serialises parallel left/right samples. The receive path deserialises an I2S stream back into parallel left/right words. It sits between the audio sample registers and the codec pins, and its two paths can be looped back for self-test.

---
 rtl/i2s_transceiver_if.sv | 39 +++
 rtl/i2s_transceiver.sv | 134 +++++++++++++
 tb/tb_i2s_transceiver.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/i2s_transceiver_if.sv
// I2S transceiver bus: sample registers on one side, codec pins on the other.
// The slave modport is the transceiver's view; the master modport is the environment's view.
interface i2s_transceiver_if #(
  parameter int AUDIO_DW = 32
);
  logic [31:0]         prescaler;
  logic [AUDIO_DW-1:0] tx_left_chan;
  logic [AUDIO_DW-1:0] tx_right_chan;
  logic                tx_lrclk;
  logic                tx_sdata;
  logic                rx_lrclk;
  logic                rx_sdata;
  logic [AUDIO_DW-1:0] rx_left_chan;
  logic [AUDIO_DW-1:0] rx_right_chan;

  modport master (
    output prescaler,
    output tx_left_chan,
    output tx_right_chan,
    output rx_lrclk,
    output rx_sdata,
    input  tx_lrclk,
    input  tx_sdata,
    input  rx_left_chan,
    input  rx_right_chan
  );

  modport slave (
    input  prescaler,
    input  tx_left_chan,
    input  tx_right_chan,
    input  rx_lrclk,
    input  rx_sdata,
    output tx_lrclk,
    output tx_sdata,
    output rx_left_chan,
    output rx_right_chan
  );
endinterface

// File: rtl/i2s_transceiver.sv
// I2S master transmitter (updates on falling sclk) and slave receiver (samples on rising sclk).
// TX generates word select and serialises samples; RX follows rx_lrclk and rebuilds MSB-aligned words.
module i2s_transceiver #(
  parameter int AUDIO_DW = 32
) (
  input  logic             sclk,
  input  logic             rst,
  i2s_transceiver_if.slave bus
);
  localparam int                CW      = $clog2(AUDIO_DW + 1);
  localparam logic [31:0]       DW_W    = 32'(AUDIO_DW);
  localparam logic [CW-1:0]     DW_C    = CW'(AUDIO_DW);
  localparam logic [AUDIO_DW-1:0] MSB_MASK = {1'b1, {(AUDIO_DW-1){1'b0}}};

  logic [31:0]         half_len_s;
  logic [31:0]         pos_k_r;
  logic [31:0]         pos_k_next_s;
  logic [31:0]         slot_s;
  logic                wrap_s;
  logic [AUDIO_DW-1:0] tx_word_r;
  logic [AUDIO_DW-1:0] tx_mask_s;
  logic                tx_bit_s;
  logic                tx_lrclk_r;
  logic                tx_sdata_r;

  logic                ws_d_r;
  logic                ws_edge_s;
  logic [CW-1:0]       bit_cnt_r;
  logic [CW-1:0]       bit_cnt_next_s;
  logic [AUDIO_DW-1:0] shift_r;
  logic [AUDIO_DW-1:0] shift_fill_s;
  logic [AUDIO_DW-1:0] rx_left_r;
  logic [AUDIO_DW-1:0] rx_right_r;

  // TX next position and the bit slot that position will drive
  always_comb begin
    half_len_s   = 32'd2;
    pos_k_next_s = 32'd0;
    slot_s       = 32'd0;
    tx_mask_s    = {AUDIO_DW{1'b0}};
    tx_bit_s     = 1'b0;
    if (bus.prescaler < 32'd2) begin
      half_len_s = 32'd2;
    end else begin
      half_len_s = bus.prescaler;
    end
    // >= keeps the counter bounded if prescaler shrinks below the current position
    wrap_s = (pos_k_r >= (half_len_s - 32'd1));
    if (wrap_s) begin
      pos_k_next_s = 32'd0;
      slot_s       = half_len_s;
    end else begin
      pos_k_next_s = pos_k_r + 32'd1;
      slot_s       = pos_k_r + 32'd1;
    end
    // slot p at k=0 is the old word's trailing bit (the I2S one-bit delay)
    if ((slot_s >= 32'd1) && (slot_s <= DW_W)) begin
      tx_mask_s = MSB_MASK >> (slot_s - 32'd1);
      tx_bit_s  = |(tx_word_r & tx_mask_s);
    end else begin
      tx_mask_s = {AUDIO_DW{1'b0}};
      tx_bit_s  = 1'b0;
    end
  end

  // TX state: position counter, word select, serial bit, word register
  always_ff @(negedge sclk) begin
    if (rst) begin
      pos_k_r    <= 32'd0;
      tx_lrclk_r <= 1'b0;
      tx_sdata_r <= 1'b0;
      tx_word_r  <= bus.tx_left_chan;
    end else begin
      pos_k_r    <= pos_k_next_s;
      tx_sdata_r <= tx_bit_s;
      if (wrap_s) begin
        tx_lrclk_r <= ~tx_lrclk_r;
        tx_word_r  <= tx_lrclk_r ? bus.tx_left_chan : bus.tx_right_chan;
      end else begin
        tx_lrclk_r <= tx_lrclk_r;
        tx_word_r  <= tx_word_r;
      end
    end
  end

  // RX shift word including this edge's bit, and word-select transition detect
  always_comb begin
    shift_fill_s   = shift_r;
    bit_cnt_next_s = bit_cnt_r;
    if (bit_cnt_r < DW_C) begin
      shift_fill_s   = shift_r | (AUDIO_DW'(bus.rx_sdata) << (DW_C - CW'(1) - bit_cnt_r));
      bit_cnt_next_s = bit_cnt_r + CW'(1);
    end else begin
      shift_fill_s   = shift_r;
      bit_cnt_next_s = bit_cnt_r;
    end
    ws_edge_s = (bus.rx_lrclk != ws_d_r);
  end

  // RX state: shift word, bit counter, delayed word select, published words
  always_ff @(posedge sclk) begin
    if (rst) begin
      ws_d_r     <= 1'b0;
      bit_cnt_r  <= {CW{1'b0}};
      shift_r    <= {AUDIO_DW{1'b0}};
      rx_left_r  <= {AUDIO_DW{1'b0}};
      rx_right_r <= {AUDIO_DW{1'b0}};
    end else begin
      ws_d_r <= bus.rx_lrclk;
      if (ws_edge_s) begin
        if (ws_d_r) begin
          rx_right_r <= shift_fill_s;
          rx_left_r  <= rx_left_r;
        end else begin
          rx_left_r  <= shift_fill_s;
          rx_right_r <= rx_right_r;
        end
        shift_r   <= {AUDIO_DW{1'b0}};
        bit_cnt_r <= {CW{1'b0}};
      end else begin
        shift_r    <= shift_fill_s;
        bit_cnt_r  <= bit_cnt_next_s;
        rx_left_r  <= rx_left_r;
        rx_right_r <= rx_right_r;
      end
    end
  end

  assign bus.tx_lrclk      = tx_lrclk_r;
  assign bus.tx_sdata      = tx_sdata_r;
  assign bus.rx_left_chan  = rx_left_r;
  assign bus.rx_right_chan = rx_right_r;

endmodule

// File: tb/tb_i2s_transceiver.sv
// Directed loopback bench for i2s_transceiver: TX pins wired to RX pins,
// expected words and timings hand-computed from the I2S framing rules.
module tb_i2s_transceiver;
  localparam int DW = 32;

  logic sclk = 1'b0;
  logic rst  = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   n;

  i2s_transceiver_if #(.AUDIO_DW(DW)) bus ();

  i2s_transceiver #(.AUDIO_DW(DW)) dut (
    .sclk (sclk),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 sclk = ~sclk;

  assign bus.rx_lrclk = bus.tx_lrclk;
  assign bus.rx_sdata = bus.tx_sdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for tx_lrclk to reach val; cnt = falling edges waited
  task automatic wait_lr(input string tag, input logic val, input int budget, output int cnt);
    cnt = 0;
    while ((bus.tx_lrclk !== val) && (cnt < budget)) begin
      @(negedge sclk);
      #1;
      cnt++;
    end
    check(tag, {31'd0, bus.tx_lrclk}, {31'd0, val});
  endtask

  // Reset spanning both edges, released just after a rising edge so both paths restart aligned
  task automatic do_reset(input int cycles);
    @(posedge sclk);
    #1 rst = 1'b1;
    repeat (cycles) @(posedge sclk);
    #1 rst = 1'b0;
  endtask

  initial begin
    bus.prescaler     = 32'd32;
    bus.tx_left_chan  = 32'h0123_4567;
    bus.tx_right_chan = 32'h89ab_cdef;

    // Reset state
    rst = 1'b1;
    repeat (10) @(posedge sclk);
    #2;
    check("rst_tx_lrclk", {31'd0, bus.tx_lrclk}, 32'd0);
    check("rst_tx_sdata", {31'd0, bus.tx_sdata}, 32'd0);
    check("rst_rx_left", bus.rx_left_chan, 32'd0);
    check("rst_rx_right", bus.rx_right_chan, 32'd0);

    // Loopback, prescaler 32
    @(posedge sclk);
    #1 rst = 1'b0;
    wait_lr("p32_rise", 1'b1, 200, n);
    wait_lr("p32_fall", 1'b0, 200, n);
    check("p32_fall_half_period", 32'(n), 32'd32);
    @(posedge sclk);
    #2;
    check("p32_rx_left", bus.rx_left_chan, 32'h0123_4567);
    check("p32_rx_right", bus.rx_right_chan, 32'h89ab_cdef);

    // Padding, prescaler 40
    bus.prescaler = 32'd40;
    do_reset(2);
    wait_lr("p40_rise", 1'b1, 200, n);
    for (int i = 1; i <= 39; i++) begin
      @(negedge sclk);
      #1;
      if (i == 1) check("p40_k1_msb", {31'd0, bus.tx_sdata}, 32'd1);
      if (i >= 33) check($sformatf("p40_pad_k%0d", i), {31'd0, bus.tx_sdata}, 32'd0);
    end
    wait_lr("p40_fall", 1'b0, 10, n);
    check("p40_half_period", 32'(39 + n), 32'd40);
    @(posedge sclk);
    #2;
    check("p40_rx_left", bus.rx_left_chan, 32'h0123_4567);
    check("p40_rx_right", bus.rx_right_chan, 32'h89ab_cdef);

    // Truncation, prescaler 16
    bus.prescaler = 32'd16;
    do_reset(2);
    wait_lr("p16_rise", 1'b1, 200, n);
    wait_lr("p16_fall", 1'b0, 200, n);
    @(posedge sclk);
    #2;
    check("p16_rx_left", bus.rx_left_chan, 32'h0123_0000);
    check("p16_rx_right", bus.rx_right_chan, 32'h89ab_0000);

    // Load timing: mid-frame change only takes effect at the next left load
    bus.prescaler = 32'd32;
    do_reset(2);
    wait_lr("load_rise0", 1'b1, 200, n);
    wait_lr("load_fall0", 1'b0, 200, n);
    repeat (10) @(negedge sclk);
    #1 bus.tx_left_chan = 32'hdead_beef;
    wait_lr("load_rise1", 1'b1, 200, n);
    @(posedge sclk);
    #2;
    check("load_cur_left", bus.rx_left_chan, 32'h0123_4567);
    wait_lr("load_fall1", 1'b0, 200, n);
    wait_lr("load_rise2", 1'b1, 200, n);
    @(posedge sclk);
    #2;
    check("load_next_left", bus.rx_left_chan, 32'hdead_beef);
    bus.tx_left_chan = 32'h0123_4567;

    // Mid-frame reset during the right half-frame
    repeat (10) @(negedge sclk);
    @(posedge sclk);
    #1 rst = 1'b1;
    @(posedge sclk);
    #1 rst = 1'b0;
    check("mrst_tx_lrclk", {31'd0, bus.tx_lrclk}, 32'd0);
    check("mrst_rx_left", bus.rx_left_chan, 32'd0);
    check("mrst_rx_right", bus.rx_right_chan, 32'd0);
    wait_lr("mrst_rise", 1'b1, 200, n);
    check("mrst_k_restart", 32'(n), 32'd32);
    @(posedge sclk);
    #2;
    check("mrst_rx_left_rec", bus.rx_left_chan, 32'h0123_4567);
    wait_lr("mrst_fall", 1'b0, 200, n);
    @(posedge sclk);
    #2;
    check("mrst_rx_right_rec", bus.rx_right_chan, 32'h89ab_cdef);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
